simple_uart_tx_arbiter: RTL and testbench
=========================================

# simple_uart_tx_arbiter

Shares the transmit side of the `simple_uart` block between several byte producers. It accepts bytes from `NB_REQ` requesters through per-requester valid/ready handshakes and grants them round-robin. It drives the UART `tx_value`/`tx_value_write` pair and paces writes to one character time, because the UART exposes no transmit-busy flag. It sits between the system's message sources and the UART instance.

## Interface
- `NB_REQ`, 4: number of requesters, 2..16.
- `SYSTEM_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: UART baud rate. Derived `CHAR_CYCLES = 10*(SYSTEM_FREQ/BAUD_RATE)` uses integer division, for example 52080 at the defaults.
- `clock` in 1: single clock for the block, rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NB_REQ: bit i means requester i has a byte pending.
- `req_data` in 8*NB_REQ: requester i's byte is at bits [8i+7:8i].
- `req_last` in NB_REQ: marks requester i's byte as end of packet. Used only under `SIMPLE_UART_ARB_LOCK_EN`.
- `req_ready` out NB_REQ: one-hot accept signal. A byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_value` out 8: byte sent to the UART.
- `tx_value_write` out 1: one-cycle write strobe to the UART.
- `grant_id` out clog2(NB_REQ): index of the last accepted requester.
- `busy` out 1: high outside IDLE.

## Operation
- FSM states:
  - IDLE: if any `req_valid` bit is set, select requester g by round-robin, searching from `grant_id+1` with wrap-around. Drive `req_ready[g]=1` combinationally in that cycle, register `req_data[g]` into `tx_value`, set `grant_id=g`, then go to SEND. If no `req_valid` bit is set, stay in IDLE with `req_ready=0`.
  - SEND: `tx_value_write=1` for exactly one cycle. Load the gap counter with `CHAR_CYCLES-2`, then go to WAIT.
  - WAIT: decrement the counter each cycle. When it reads 0, go to IDLE. `req_ready=0` throughout.
- `req_ready` is only ever non-zero in IDLE, and at most one bit is set.
- Counter width is clog2(CHAR_CYCLES). Parameters must give `CHAR_CYCLES ≥ 3`.
- Requesters may drop `req_valid` at any time without a transfer, and no byte is lost. `req_data` is sampled only in the accept cycle.
- `tx_value` holds the last sent byte until the next accept.
- Reset values:
  - all outputs 0, with `tx_value=8'h00`, `grant_id=NB_REQ-1` so that requester 0 wins first, and `busy=0`.
  - FSM in IDLE, counter 0, lock cleared.
- Asserting reset mid-operation takes effect immediately, including mid-strobe. Bytes already written are not recalled. The byte being paced is dropped from the arbiter's view.

## Timing
- Accept in cycle N gives `tx_value_write` in cycle N+1 with `tx_value` already stable.
- WAIT lasts `CHAR_CYCLES-1` cycles, spanning cycles N+2 to N+CHAR_CYCLES.
- The earliest next accept is cycle N+CHAR_CYCLES+1. Consecutive write strobes are therefore spaced exactly `CHAR_CYCLES+1` cycles under continuous demand.
- `busy` rises in cycle N+1 and falls when IDLE is re-entered.
- Simultaneous requests resolve in a single cycle; the arbiter never spends an idle cycle on arbitration.

## Configuration
- `SIMPLE_UART_ARB_LOCK_EN` defined (packet lock):
  - An accepted byte with `req_last[g]=0` sets the lock to g.
  - While the lock is set, IDLE considers only requester g. Other requesters wait even when `req_valid[g]=0`.
  - An accepted byte with `req_last[g]=1` clears the lock. Round-robin then resumes from g+1.
- Undefined:
  - `req_last` is ignored and no lock logic is built.
  - The grant rotates after every byte.

## Test plan
Benches use `SYSTEM_FREQ=1_000_000`, `BAUD_RATE=100_000` (so `CHAR_CYCLES=100`) and `NB_REQ=4`.
- Reset: hold `arst_n=0` with `req_valid=4'hF`. Expect `req_ready=0`, `tx_value_write=0`, `tx_value=0`, `busy=0`, `grant_id=3`.
- Single byte: `req_valid=4'b0100`, `req_data[23:16]=8'hA5` at cycle N. Expect `req_ready=4'b0100` at N, `tx_value_write=1` with `tx_value=8'hA5` at N+1 only, and `busy` low again at N+101.
- Fairness: all four valid with bytes 8'h10/11/12/13, held continuously. Expect strobes carrying 10, 11, 12, 13, 10, … at 101-cycle spacing.
- Lock (macro on):
  - Requester 1 sends 8'h01 (last=0), then 8'h02 (last=1), while requester 0 stays valid.
  - Expect the order 01, 02, then requester 0's byte.
  - With the macro off, expect 01, then requester 0's byte.
- Mid-operation reset: pulse `arst_n` low for 3 cycles at cycle 50 of WAIT. Expect immediate return to reset values, and the next accept in the first cycle after release when valid is high.
- Valid withdrawal: requester 2 raises valid only during WAIT and drops it before IDLE. Expect no `req_ready[2]` and no strobe.

Source files
------------

// File: rtl/simple_uart_tx_arbiter.sv
// rtl/simple_uart_tx_arbiter.sv - round-robin byte arbiter pacing writes into the simple_uart transmitter
// Optional packet lock when SIMPLE_UART_ARB_LOCK_EN is defined.
module simple_uart_tx_arbiter #(
   parameter int NB_REQ      = 4,
   parameter int SYSTEM_FREQ = 50_000_000,
   parameter int BAUD_RATE   = 9600
) (
   input  logic                      clock,
   input  logic                      arst_n,
   input  logic [NB_REQ-1:0]         req_valid,
   input  logic [8*NB_REQ-1:0]       req_data,
   input  logic [NB_REQ-1:0]         req_last,
   output logic [NB_REQ-1:0]         req_ready,
   output logic [7:0]                tx_value,
   output logic                      tx_value_write,
   output logic [$clog2(NB_REQ)-1:0] grant_id,
   output logic                      busy
);

   localparam int GW          = $clog2(NB_REQ);
   localparam int CHAR_CYCLES = 10 * (SYSTEM_FREQ / BAUD_RATE);
   localparam int CW          = $clog2(CHAR_CYCLES);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t        state;
   logic [CW-1:0] gap_cnt;
   logic [GW-1:0] pick;
   logic          pick_ok;

`ifdef SIMPLE_UART_ARB_LOCK_EN
   logic          lock_on;
   logic [GW-1:0] lock_id;
`else
   logic          unused_last;
   assign unused_last = ^req_last;
`endif

   // First valid requester after the previous grant, wrapping around.
   always_comb begin
      pick    = grant_id;
      pick_ok = 1'b0;
      for (int k = 1; k <= NB_REQ; k++) begin
         if (!pick_ok && req_valid[(int'(grant_id) + k) % NB_REQ]) begin
            pick    = GW'((int'(grant_id) + k) % NB_REQ);
            pick_ok = 1'b1;
         end
      end
`ifdef SIMPLE_UART_ARB_LOCK_EN
      if (lock_on) begin
         pick    = lock_id;
         pick_ok = req_valid[lock_id];
      end
`endif
   end

   always_comb begin
      req_ready = '0;
      if (arst_n && state == IDLE && pick_ok)
         req_ready[pick] = 1'b1;
   end

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         state          <= IDLE;
         gap_cnt        <= '0;
         tx_value       <= 8'h00;
         tx_value_write <= 1'b0;
         grant_id       <= GW'(NB_REQ - 1);
         busy           <= 1'b0;
`ifdef SIMPLE_UART_ARB_LOCK_EN
         lock_on        <= 1'b0;
         lock_id        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  tx_value       <= req_data[8*int'(pick) +: 8];
                  grant_id       <= pick;
                  tx_value_write <= 1'b1;
                  busy           <= 1'b1;
                  state          <= SEND;
`ifdef SIMPLE_UART_ARB_LOCK_EN
                  lock_on        <= !req_last[pick];
                  lock_id        <= pick;
`endif
               end
            end
            SEND: begin
               tx_value_write <= 1'b0;
               gap_cnt        <= CW'(CHAR_CYCLES - 2);
               state          <= WAIT;
            end
            WAIT: begin
               // The UART has no busy flag, so the gap alone guarantees the character finished.
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_uart_tx_arbiter.sv
// tb/tb_simple_uart_tx_arbiter.sv - self-checking bench for simple_uart_tx_arbiter
// Timestamp-based reference model plus directed scenarios with literal expectations.
module tb_simple_uart_tx_arbiter;

   localparam int CH = 100;

   logic        clock = 1'b0;
   logic        arst_n = 1'b0;
   logic [3:0]  req_valid = 4'h0;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  req_last = 4'h0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_value;
   logic        tx_value_write;
   logic [1:0]  grant_id;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   int         s_cyc[$];
   logic [7:0] s_val[$];
   bit         seen2 = 1'b0;

   simple_uart_tx_arbiter #(
      .NB_REQ(4), .SYSTEM_FREQ(1_000_000), .BAUD_RATE(100_000)
   ) dut (
      .clock(clock), .arst_n(arst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_value(tx_value), .tx_value_write(tx_value_write),
      .grant_id(grant_id), .busy(busy)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int ncyc);
      arst_n = 1'b0;
      repeat (ncyc) tick();
      arst_n = 1'b1;
   endtask

   task automatic wait_ready(input int idx, input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (req_ready[idx]) begin
            at = cyc;
            break;
         end
         tick();
      end
      chk($sformatf("ready%0d_within_bound", idx), (at >= 0), 1);
   endtask

   task automatic wait_strobes(input int n, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (s_val.size() >= n) break;
         tick();
      end
      chk("strobe_count_within_bound", (s_val.size() >= n), 1);
   endtask

   // Reference model: the arbiter is idle from CH+1 cycles after its last accept.
   int         m_acc = -100000;
   int         m_grant = 3;
   logic [7:0] m_tx = 8'h00;
   bit         m_lock = 1'b0;
   int         m_lock_id = 0;

   always @(negedge clock) begin
      logic [3:0] er;
      int g;
      if (tx_value_write) begin
         s_cyc.push_back(cyc);
         s_val.push_back(tx_value);
      end
      if (req_ready[2]) seen2 = 1'b1;
      if (!arst_n) begin
         m_acc = -100000; m_grant = 3; m_tx = 8'h00; m_lock = 1'b0; m_lock_id = 0;
         chk("model_rst_ready", req_ready, 4'h0);
         chk("model_rst_write", tx_value_write, 1'b0);
         chk("model_rst_busy", busy, 1'b0);
         chk("model_rst_tx", tx_value, 8'h00);
         chk("model_rst_grant", grant_id, 2'd3);
      end else begin
         g = -1;
         if (cyc >= m_acc + CH + 1) begin
            if (m_lock) begin
               if (req_valid[m_lock_id]) g = m_lock_id;
            end else begin
               for (int k = 1; k <= 4; k++)
                  if (g < 0 && req_valid[(m_grant + k) % 4]) g = (m_grant + k) % 4;
            end
         end
         er = 4'h0;
         if (g >= 0) er[g] = 1'b1;
         chk("model_ready", req_ready, er);
         chk("model_write", tx_value_write, (cyc == m_acc + 1));
         chk("model_busy", busy, (cyc < m_acc + CH + 1));
         chk("model_tx", tx_value, m_tx);
         chk("model_grant", grant_id, m_grant[1:0]);
         if (g >= 0) begin
            m_acc = cyc;
            m_grant = g;
            m_tx = req_data[8*g +: 8];
`ifdef SIMPLE_UART_ARB_LOCK_EN
            m_lock = !req_last[g];
            m_lock_id = g;
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, s0;
      logic [7:0] exp_order[4];

      // Reset with every requester asking.
      req_valid = 4'hF;
      repeat (3) tick();
      @(negedge clock);
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_write", tx_value_write, 1'b0);
      chk("rst_tx", tx_value, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant_id, 2'd3);
      tick();
      req_valid = 4'h0;
      arst_n = 1'b1;
      repeat (2) tick();

      // Single byte from requester 2.
      req_valid = 4'b0100;
      req_data[23:16] = 8'hA5;
      n = cyc;
      @(negedge clock);
      chk("single_ready", req_ready, 4'b0100);
      tick();
      req_valid = 4'h0;
      req_data[23:16] = 8'h00;
      @(negedge clock);
      chk("single_write", tx_value_write, 1'b1);
      chk("single_tx", tx_value, 8'hA5);
      chk("single_busy_rise", busy, 1'b1);
      tick();
      @(negedge clock);
      chk("single_write_once", tx_value_write, 1'b0);
      chk("single_grant", grant_id, 2'd2);
      while (cyc < n + 100) tick();
      @(negedge clock);
      chk("single_busy_n100", busy, 1'b1);
      tick();
      @(negedge clock);
      chk("single_busy_n101", busy, 1'b0);

      // Fairness: all four held valid from reset release.
      tick();
      req_data = 32'h13121110;
      req_valid = 4'hF;
      do_reset(2);
      s0 = s_val.size();
      wait_strobes(s0 + 5, 700);
      req_valid = 4'h0;
      if (s_val.size() >= s0 + 5) begin
         chk("fair_b0", s_val[s0], 8'h10);
         chk("fair_b1", s_val[s0+1], 8'h11);
         chk("fair_b2", s_val[s0+2], 8'h12);
         chk("fair_b3", s_val[s0+3], 8'h13);
         chk("fair_b4", s_val[s0+4], 8'h10);
         for (int k = 1; k < 5; k++)
            chk($sformatf("fair_spacing%0d", k), s_cyc[s0+k] - s_cyc[s0+k-1], CH + 1);
      end

      // Packet lock: requester 1 sends two bytes while requester 0 waits.
      tick();
      req_data = 32'h00000077;
      req_last = 4'h0;
      req_valid = 4'b0001;
      s0 = s_val.size();
      do_reset(2);
      wait_ready(0, 5, n);
      tick();
      req_valid = 4'b0000;
      repeat (10) tick();
      req_data[7:0] = 8'h55;
      req_last[0] = 1'b1;
      req_data[15:8] = 8'h01;
      req_last[1] = 1'b0;
      req_valid = 4'b0011;
      wait_ready(1, 300, n);
      tick();
      req_data[15:8] = 8'h02;
      req_last[1] = 1'b1;
      wait_ready(1, 500, n);
      tick();
      req_valid[1] = 1'b0;
      wait_strobes(s0 + 4, 500);
      req_valid = 4'h0;
`ifdef SIMPLE_UART_ARB_LOCK_EN
      exp_order = '{8'h77, 8'h01, 8'h02, 8'h55};
`else
      exp_order = '{8'h77, 8'h01, 8'h55, 8'h02};
`endif
      if (s_val.size() >= s0 + 4)
         for (int k = 0; k < 4; k++)
            chk($sformatf("lock_order%0d", k), s_val[s0+k], exp_order[k]);

      // Reset pulse in the middle of WAIT.
      tick();
      req_data = 32'h0000003C;
      req_last = 4'h0;
      req_valid = 4'b0001;
      do_reset(2);
      wait_ready(0, 5, n);
      tick();
      req_valid = 4'h0;
      while (cyc < n + 52) tick();
      arst_n = 1'b0;
      req_valid = 4'b0010;
      req_data[15:8] = 8'h99;
      @(negedge clock);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_grant", grant_id, 2'd3);
      chk("midrst_tx", tx_value, 8'h00);
      chk("midrst_ready", req_ready, 4'h0);
      repeat (3) tick();
      arst_n = 1'b1;
      m = cyc;
      @(negedge clock);
      chk("midrst_first_accept", req_ready, 4'b0010);
      tick();
      req_valid = 4'h0;
      @(negedge clock);
      chk("midrst_write", tx_value_write, 1'b1);
      chk("midrst_tx_after", tx_value, 8'h99);

      // Requester 2 asks only while the arbiter is pacing.
      while (cyc < m + 20) tick();
      req_data[23:16] = 8'hEE;
      req_valid = 4'b0100;
      seen2 = 1'b0;
      while (cyc < m + 80) tick();
      req_valid = 4'h0;
      s0 = s_val.size();
      while (cyc < m + 110) tick();
      @(negedge clock);
      chk("withdraw_no_strobe", s_val.size(), s0);
      chk("withdraw_no_ready2", seen2, 1'b0);
      chk("withdraw_grant", grant_id, 2'd1);
      chk("withdraw_idle", busy, 1'b0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
